cpu_seq_ctrl: RTL and testbench
===============================

// Module: cpu_seq_ctrl
// PURPOSE
//  Multi-cycle fetch-decode-execute sequencer for the 4-bit mini processor.
//  Fetches 8-bit instructions {opcode[7:6], rd[5:4], rs1[3:2], rs2[1:0]} over a
//  req/ack instruction-memory port. Drives the register-bank read/write selects
//  and the ALU opcode, one instruction at a time. Adds start/halt control, a
//  fetch timeout and a retired-instruction counter around the existing ALU and
//  register bank.
// PARAMETERS
//  ADDR_W      3      PC / instruction-address width; PC wraps mod 2**ADDR_W
//  HALT_INSTR  8'hFF  instruction word decoded as HALT (not executed)
//  MAX_WAIT    15     max FETCH cycles without imem_ack before ERROR (1..255)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low (0 = reset)
//  start       in   1       1-cycle pulse; starts run at PC=0 from IDLE/HALT/ERROR
//  imem_req    out  1       instruction fetch request
//  imem_addr   out  ADDR_W  fetch address (= pc)
//  imem_ack    in   1       memory has valid imem_rdata this cycle
//  imem_rdata  in   8       instruction word
//  alu_op      out  2       00 ADD, 01 SUB, 10 AND, 11 OR
//  rd          out  2       write-register select
//  rs1         out  2       ALU operand A register select
//  rs2         out  2       ALU operand B register select
//  rf_we       out  1       register-bank write enable (writes ALU result to rd)
//  pc          out  ADDR_W  program counter
//  busy        out  1       1 in FETCH/DECODE/EXECUTE/WRITEBACK
//  halted      out  1       1 in HALT
//  err_timeout out  1       1 in ERROR
//  retired     out  8       instructions written back since start; saturates at 255
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE. All outputs 0. ir=0. Wait counter=0.
//  States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, ERROR.
//  IDLE/HALT/ERROR + start=1: pc<=0, retired<=0, wait<=0. Then -> FETCH.
//   start is ignored in all other states.
//  FETCH: imem_req=1 and imem_addr=pc, held stable until ack.
//   - imem_ack=1: ir<=imem_rdata, wait<=0, -> DECODE.
//   - no ack: wait<=wait+1. If wait==MAX_WAIT-1, -> ERROR with imem_req=0 next cycle.
//   - imem_ack is ignored while imem_req=0.
//  DECODE:
//   - ir==HALT_INSTR: -> HALT. pc is not incremented and retired is unchanged.
//   - otherwise: -> EXECUTE.
//  alu_op/rd/rs1/rs2 are combinational slices of ir, valid from DECODE onward.
//   They hold their value until the next ack.
//  EXECUTE: one cycle for the combinational ALU to settle. rf_we=0. -> WRITEBACK.
//  WRITEBACK: rf_we=1 for exactly this cycle. pc<=pc+1 (wraps from 2**ADDR_W-1
//   to 0). retired<=retired+1, saturating at 255. -> FETCH.
//  Latency: 4 cycles per instruction when ack arrives in the first FETCH cycle,
//   plus 1 cycle per wait cycle. rf_we is never asserted outside WRITEBACK.
//  Reset asserted mid-instruction: immediate return to IDLE. The pending fetch
//   is abandoned and rf_we drops asynchronously.
// TESTING
//  1. Reset, start, ack same cycle for the 4-instr program ending in 8'hFF
//     -> rf_we pulses at cycles 4, 8, 12, 16 after start. halted=1, pc=4, retired=4.
//  2. Fetch 8'b00_11_00_01 -> in EXECUTE alu_op=00, rd=3, rs1=0, rs2=1.
//     rf_we=1 exactly 1 cycle.
//  3. Delay ack by 3 cycles on each fetch -> imem_req/imem_addr stable while waiting.
//     Per-instruction period is 7 cycles.
//  4. Never ack -> err_timeout=1 after 15 FETCH cycles, imem_req=0.
//     A later start restarts at pc=0.
//  5. Program of 9 non-HALT words -> pc wraps 7->0.
//     Start pulses while busy have no effect.
//  6. Assert reset during EXECUTE -> all outputs 0 immediately.
//     After release, state is IDLE until start.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit mini processor.
// Drives register-bank selects and ALU opcode; adds start/halt, fetch timeout and a retired counter.
module cpu_seq_ctrl #(
  parameter int         ADDR_W     = 3,
  parameter logic [7:0] HALT_INSTR = 8'hFF,
  parameter int         MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic [1:0]        alu_op,
  output logic [1:0]        rd,
  output logic [1:0]        rs1,
  output logic [1:0]        rs2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err_timeout,
  output logic [7:0]        retired,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          retired_q, retired_d;
  logic [7:0]          wait_q, wait_d;
  logic [7:0]          ir_q, ir_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      ir_q      <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    ir_d      = ir_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          pc_d      = '0;
          retired_d = '0;
          wait_d    = '0;
          state_d   = S_FETCH;
        end
      end
      // Fetch handshake: imem_req stays high with imem_addr stable until a cycle
      // in which imem_ack=1; that cycle transfers imem_rdata. imem_ack is ignored
      // whenever imem_req=0.
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else begin
          wait_d = 8'(wait_q + 8'd1);
          if (wait_q == WAIT_LAST) state_d = S_ERROR;
        end
      end
      S_DECODE: state_d = (ir_q == HALT_INSTR) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        pc_d = pc_q + ADDR_W'(1);
        if (retired_q != 8'hFF) retired_d = 8'(retired_q + 8'd1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so rf_we falls the instant reset asserts.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign rf_we       = (state_q == S_WRITEBACK);
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted      = (state_q == S_HALT);
  assign err_timeout = (state_q == S_ERROR);
  assign alu_op      = ir_q[7:6];
  assign rd          = ir_q[5:4];
  assign rs1         = ir_q[3:2];
  assign rs2         = ir_q[1:0];
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: an instruction-memory responder with random ack delay,
// checked against a per-instruction timing/architectural model.
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       imem_req;
  logic [2:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic [1:0] alu_op, rd, rs1, rs2;
  logic       rf_we;
  logic [2:0] pc;
  logic       busy, halted, err_timeout;
  logic [7:0] retired;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [8];
  logic [7:0] exp_q [$];

  cpu_seq_ctrl #(.ADDR_W(3), .HALT_INSTR(8'hFF), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted),
    .err_timeout(err_timeout), .retired(retired), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_instr();
    return 8'($urandom_range(0, 254));
  endfunction

  // Model: instruction k fetches from pc, waits d cycles for ack, then spends one
  // cycle each in decode, execute and writeback (rf_we), then fetches pc+1.
  // HALT is recognised at decode and leaves pc/retired untouched.
  task automatic run_program(input int n_instr, input int dmin, input int dmax, input bit noisy);
    int mpc, mret, d;
    logic [7:0] w;
    do_start();
    mpc = 0;
    mret = 0;
    for (int k = 0; k < n_instr; k++) begin
      w = mem[mpc];
      d = $urandom_range(dmin, dmax);
      for (int i = 0; i <= d; i++) begin
        checks++;
        if ({imem_req, imem_addr, rf_we, busy, retired} !== {1'b1, mpc[2:0], 1'b0, 1'b1, mret[7:0]}) begin
          failures++;
          $display("FAIL fetch k=%0d i=%0d: got req=%b addr=%0d we=%b busy=%b ret=%0d, exp req=1 addr=%0d we=0 busy=1 ret=%0d",
                   k, i, imem_req, imem_addr, rf_we, busy, retired, mpc, mret);
        end
        imem_ack = (i == d);
        imem_rdata = (i == d) ? w : 8'($urandom);
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
      end
      if (w == 8'hFF) begin
        imem_ack = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if ({halted, busy, rf_we, imem_req, pc, retired} !== {1'b1, 1'b0, 1'b0, 1'b0, mpc[2:0], mret[7:0]}) begin
          failures++;
          $display("FAIL halt: got halted=%b busy=%b we=%b req=%b pc=%0d ret=%0d, exp 1 0 0 0 pc=%0d ret=%0d",
                   halted, busy, rf_we, imem_req, pc, retired, mpc, mret);
        end
        return;
      end
      // decode, execute, writeback; ack/rdata noise must be ignored here
      for (int s = 0; s < 3; s++) begin
        checks++;
        if ({alu_op, rd, rs1, rs2, busy, rf_we, imem_req, pc} !== {w, 1'b1, 1'(s == 2), 1'b0, mpc[2:0]}) begin
          failures++;
          $display("FAIL exec k=%0d s=%0d: got ir=%h busy=%b we=%b req=%b pc=%0d, exp ir=%h busy=1 we=%b req=0 pc=%0d",
                   k, s, {alu_op, rd, rs1, rs2}, busy, rf_we, imem_req, pc, w, (s == 2), mpc);
        end
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = 8'($urandom);
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
      end
      exp_q.push_back(w);
      mpc = (mpc + 1) % 8;
      mret = (mret < 255) ? mret + 1 : 255;
    end
    imem_ack = 1'b0;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({imem_req, imem_addr, alu_op, rd, rs1, rs2, rf_we, pc, busy, halted, err_timeout, retired} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h exp 0", {imem_req, imem_addr, alu_op, rd, rs1, rs2, rf_we, pc, busy, halted, err_timeout, retired});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = 8'($urandom);
      step();
      checks++;
      if ({busy, halted, err_timeout, imem_req, alu_op, rd, rs1, rs2} !== 12'd0) begin
        failures++;
        $display("FAIL idle_hold: got busy=%b halted=%b err=%b req=%b ir=%h exp all 0",
                 busy, halted, err_timeout, imem_req, {alu_op, rd, rs1, rs2});
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_program_halt();
    mem[0] = 8'b00_11_00_01;
    for (int i = 1; i < 4; i++) mem[i] = rand_instr();
    mem[4] = 8'hFF;
    for (int i = 5; i < 8; i++) mem[i] = rand_instr();
    run_program(20, 0, 0, 1'b0);
    checks++;
    if ({halted, pc, retired} !== {1'b1, 3'd4, 8'd4}) begin
      failures++;
      $display("FAIL program_halt: got halted=%b pc=%0d ret=%0d exp halted=1 pc=4 ret=4", halted, pc, retired);
    end
    checks++;
    if (exp_q.size() != 4 || exp_q[0] !== 8'b00_11_00_01) begin
      failures++;
      $display("FAIL first_instr: got writebacks=%0d exp 4 with first 31", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_wait_states();
    int hpos;
    hpos = $urandom_range(2, 7);
    for (int i = 0; i < 8; i++) mem[i] = (i == hpos) ? 8'hFF : rand_instr();
    run_program(20, 3, 3, 1'b0);
    for (int i = 0; i < 8; i++) mem[i] = (i == 5) ? 8'hFF : rand_instr();
    run_program(20, 0, 4, 1'b0);
  endtask

  task automatic test_timeout();
    do_start();
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({imem_req, err_timeout, imem_addr} !== {1'b1, 1'b0, 3'd0}) begin
        failures++;
        $display("FAIL timeout_wait i=%0d: got req=%b err=%b addr=%0d exp req=1 err=0 addr=0", i, imem_req, err_timeout, imem_addr);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({imem_req, err_timeout, busy} !== 3'b010) begin
        failures++;
        $display("FAIL timeout_err i=%0d: got req=%b err=%b busy=%b exp req=0 err=1 busy=0", i, imem_req, err_timeout, busy);
      end
      imem_ack = 1'b1;
      step();
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = (i == 2) ? 8'hFF : rand_instr();
    run_program(20, 0, 2, 1'b0);
  endtask

  task automatic test_wrap_busy_start();
    for (int i = 0; i < 8; i++) mem[i] = rand_instr();
    run_program(11, 0, 2, 1'b1);
    checks++;
    if ({pc, retired, busy} !== {3'd3, 8'd11, 1'b1}) begin
      failures++;
      $display("FAIL wrap: got pc=%0d ret=%0d busy=%b exp pc=3 ret=11 busy=1", pc, retired, busy);
    end
    exp_q.delete();
    do_reset();
  endtask

  task automatic test_reset_mid();
    for (int tgt = 2; tgt <= 3; tgt++) begin
      mem[0] = rand_instr();
      do_start();
      imem_ack = 1'b1;
      imem_rdata = mem[0];
      step();
      imem_ack = 1'b0;
      for (int c = 1; c < tgt; c++) step();
      checks++;
      if ({busy, rf_we} !== {1'b1, 1'(tgt == 3)}) begin
        failures++;
        $display("FAIL pre_reset tgt=%0d: got busy=%b we=%b exp busy=1 we=%b", tgt, busy, rf_we, (tgt == 3));
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, alu_op, rd, rs1, rs2, rf_we, pc, busy, halted, err_timeout, retired} !== 27'd0) begin
        failures++;
        $display("FAIL async_reset tgt=%0d: got %h exp 0", tgt, {imem_req, imem_addr, alu_op, rd, rs1, rs2, rf_we, pc, busy, halted, err_timeout, retired});
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        step();
        checks++;
        if ({busy, halted, err_timeout, imem_req, rf_we} !== 5'd0) begin
          failures++;
          $display("FAIL post_reset_idle i=%0d: got busy=%b halted=%b err=%b req=%b we=%b exp all 0",
                   i, busy, halted, err_timeout, imem_req, rf_we);
        end
      end
      imem_ack = 1'b0;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) mem[i] = rand_instr();
    run_program(258, 0, 0, 1'b0);
    checks++;
    if (retired !== 8'd255) begin
      failures++;
      $display("FAIL saturate: got ret=%0d exp 255", retired);
    end
    exp_q.delete();
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) mem[i] = (i == 1) ? 8'hFF : rand_instr();
    run_program(5, 0, 1, 1'b0);
    run_program(5, 0, 1, 1'b0);
    mem[0] = 8'hFF;
    run_program(3, 0, 0, 1'b0);
    checks++;
    if ({halted, pc, retired} !== {1'b1, 3'd0, 8'd0}) begin
      failures++;
      $display("FAIL halt_at_0: got halted=%b pc=%0d ret=%0d exp 1 0 0", halted, pc, retired);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_program_halt();
    test_wait_states();
    test_timeout();
    test_wrap_busy_start();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
